// File: rtl/axil_xbar.sv
// rtl/axil_xbar.sv - AXI4-Lite 1:N crossbar, one outstanding txn per direction; optional AXIL_XBAR_DECERR_EN
module axil_xbar #(
    parameter int C_NUM_MASTER_SLOTS = 2,
    parameter int C_AXI_ADDR_WIDTH   = 32,
    parameter int C_AXI_DATA_WIDTH   = 32,
    parameter logic [C_NUM_MASTER_SLOTS*C_AXI_ADDR_WIDTH-1:0] C_M_AXI_BASE_ADDR = '0,
    parameter logic [C_NUM_MASTER_SLOTS*32-1:0] C_M_AXI_ADDR_WIDTH = {C_NUM_MASTER_SLOTS{32'd12}}
) (
    input  logic                                        aclk,
    input  logic                                        aresetn,
    input  logic [C_AXI_ADDR_WIDTH-1:0]                 s_axi_awaddr,
    input  logic [2:0]                                  s_axi_awprot,
    input  logic                                        s_axi_awvalid,
    output logic                                        s_axi_awready,
    input  logic [C_AXI_DATA_WIDTH-1:0]                 s_axi_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]               s_axi_wstrb,
    input  logic                                        s_axi_wvalid,
    output logic                                        s_axi_wready,
    output logic [1:0]                                  s_axi_bresp,
    output logic                                        s_axi_bvalid,
    input  logic                                        s_axi_bready,
    input  logic [C_AXI_ADDR_WIDTH-1:0]                 s_axi_araddr,
    input  logic [2:0]                                  s_axi_arprot,
    input  logic                                        s_axi_arvalid,
    output logic                                        s_axi_arready,
    output logic [C_AXI_DATA_WIDTH-1:0]                 s_axi_rdata,
    output logic [1:0]                                  s_axi_rresp,
    output logic                                        s_axi_rvalid,
    input  logic                                        s_axi_rready,
    output logic [C_NUM_MASTER_SLOTS*C_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [C_NUM_MASTER_SLOTS*3-1:0]                  m_axi_awprot,
    output logic [C_NUM_MASTER_SLOTS-1:0]                    m_axi_awvalid,
    input  logic [C_NUM_MASTER_SLOTS-1:0]                    m_axi_awready,
    output logic [C_NUM_MASTER_SLOTS*C_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_NUM_MASTER_SLOTS*C_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic [C_NUM_MASTER_SLOTS-1:0]                    m_axi_wvalid,
    input  logic [C_NUM_MASTER_SLOTS-1:0]                    m_axi_wready,
    input  logic [C_NUM_MASTER_SLOTS*2-1:0]                  m_axi_bresp,
    input  logic [C_NUM_MASTER_SLOTS-1:0]                    m_axi_bvalid,
    output logic [C_NUM_MASTER_SLOTS-1:0]                    m_axi_bready,
    output logic [C_NUM_MASTER_SLOTS*C_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [C_NUM_MASTER_SLOTS*3-1:0]                  m_axi_arprot,
    output logic [C_NUM_MASTER_SLOTS-1:0]                    m_axi_arvalid,
    input  logic [C_NUM_MASTER_SLOTS-1:0]                    m_axi_arready,
    input  logic [C_NUM_MASTER_SLOTS*C_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [C_NUM_MASTER_SLOTS*2-1:0]                  m_axi_rresp,
    input  logic [C_NUM_MASTER_SLOTS-1:0]                    m_axi_rvalid,
    output logic [C_NUM_MASTER_SLOTS-1:0]                    m_axi_rready
);
    localparam int N  = C_NUM_MASTER_SLOTS;
    localparam int AW = C_AXI_ADDR_WIDTH;
    localparam int DW = C_AXI_DATA_WIDTH;
    localparam int SW = (N > 1) ? $clog2(N) : 1;

`ifdef AXIL_XBAR_DECERR_EN
    localparam logic DECERR = 1'b1;
`else
    localparam logic DECERR = 1'b0;
`endif

    localparam logic [1:0] W_IDLE = 2'd0, W_FWD = 2'd1, W_RESP = 2'd2;
    localparam logic [1:0] R_IDLE = 2'd0, R_FWD = 2'd1, R_DATA = 2'd2;

    // Returns {miss, slot}; scanning downward lets the lowest index win on overlap.
    // A miss leaves slot 0, which is where unmapped traffic goes without DECERR.
    function automatic logic [SW:0] decode(input logic [AW-1:0] addr);
        logic [SW:0]   r;
        logic [AW-1:0] mask;
        r = {1'b1, {SW{1'b0}}};
        for (int i = N - 1; i >= 0; i--) begin
            mask = {AW{1'b1}} << C_M_AXI_ADDR_WIDTH[i*32 +: 32];
            if ((addr & mask) == (C_M_AXI_BASE_ADDR[i*AW +: AW] & mask))
                r = {1'b0, SW'(i)};
        end
        return r;
    endfunction

    logic          init_q;
    logic [1:0]    w_state_q, w_state_d, r_state_q, r_state_d;
    logic [AW-1:0] aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
    logic [2:0]    aw_prot_q, aw_prot_d, ar_prot_q, ar_prot_d;
    logic [SW-1:0] aw_sel_q, aw_sel_d, ar_sel_q, ar_sel_d;
    logic          aw_miss_q, aw_miss_d, ar_miss_q, ar_miss_d;
    logic          aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [SW:0]   aw_dec, ar_dec;

    assign aw_dec = decode(s_axi_awaddr);
    assign ar_dec = decode(s_axi_araddr);

    // Address, prot and write data are broadcast; only valid/ready are slot-gated.
    assign m_axi_awaddr = {N{aw_addr_q}};
    assign m_axi_awprot = {N{aw_prot_q}};
    assign m_axi_araddr = {N{ar_addr_q}};
    assign m_axi_arprot = {N{ar_prot_q}};
    assign m_axi_wdata  = {N{s_axi_wdata}};
    assign m_axi_wstrb  = {N{s_axi_wstrb}};

    // Write channel FSM: accept AW, forward AW and one W beat, then route B back.
    always_comb begin
        w_state_d     = w_state_q;
        aw_addr_d     = aw_addr_q;
        aw_prot_d     = aw_prot_q;
        aw_sel_d      = aw_sel_q;
        aw_miss_d     = aw_miss_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        s_axi_awready = init_q && (w_state_q == W_IDLE);
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bresp   = 2'b00;
        m_axi_awvalid = '0;
        m_axi_wvalid  = '0;
        m_axi_bready  = '0;
        case (w_state_q)
            W_IDLE: begin
                if (s_axi_awvalid && s_axi_awready) begin
                    aw_addr_d = s_axi_awaddr;
                    aw_prot_d = s_axi_awprot;
                    aw_sel_d  = aw_dec[SW] ? '0 : aw_dec[SW-1:0];
                    aw_miss_d = DECERR && aw_dec[SW];
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    w_state_d = W_FWD;
                end
            end
            W_FWD: begin
                if (aw_miss_q) begin
                    aw_done_d    = 1'b1;
                    s_axi_wready = !w_done_q;
                end else begin
                    m_axi_awvalid[aw_sel_q] = !aw_done_q;
                    m_axi_wvalid[aw_sel_q]  = s_axi_wvalid && !w_done_q;
                    s_axi_wready            = m_axi_wready[aw_sel_q] && !w_done_q;
                    if (!aw_done_q && m_axi_awready[aw_sel_q])
                        aw_done_d = 1'b1;
                end
                if (s_axi_wvalid && s_axi_wready)
                    w_done_d = 1'b1;
                if (aw_done_d && w_done_d)
                    w_state_d = W_RESP;
            end
            W_RESP: begin
                if (aw_miss_q) begin
                    s_axi_bvalid = 1'b1;
                    s_axi_bresp  = 2'b11;
                end else begin
                    s_axi_bvalid           = m_axi_bvalid[aw_sel_q];
                    s_axi_bresp            = m_axi_bresp[aw_sel_q*2 +: 2];
                    m_axi_bready[aw_sel_q] = s_axi_bready;
                end
                if (s_axi_bvalid && s_axi_bready)
                    w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read channel FSM: accept AR, forward it, then route the single R beat back.
    always_comb begin
        r_state_d     = r_state_q;
        ar_addr_d     = ar_addr_q;
        ar_prot_d     = ar_prot_q;
        ar_sel_d      = ar_sel_q;
        ar_miss_d     = ar_miss_q;
        s_axi_arready = init_q && (r_state_q == R_IDLE);
        s_axi_rvalid  = 1'b0;
        s_axi_rresp   = 2'b00;
        s_axi_rdata   = '0;
        m_axi_arvalid = '0;
        m_axi_rready  = '0;
        case (r_state_q)
            R_IDLE: begin
                if (s_axi_arvalid && s_axi_arready) begin
                    ar_addr_d = s_axi_araddr;
                    ar_prot_d = s_axi_arprot;
                    ar_sel_d  = ar_dec[SW] ? '0 : ar_dec[SW-1:0];
                    ar_miss_d = DECERR && ar_dec[SW];
                    r_state_d = R_FWD;
                end
            end
            R_FWD: begin
                if (ar_miss_q) begin
                    r_state_d = R_DATA;
                end else begin
                    m_axi_arvalid[ar_sel_q] = 1'b1;
                    if (m_axi_arready[ar_sel_q])
                        r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (ar_miss_q) begin
                    s_axi_rvalid = 1'b1;
                    s_axi_rresp  = 2'b11;
                end else begin
                    s_axi_rvalid           = m_axi_rvalid[ar_sel_q];
                    s_axi_rresp            = m_axi_rresp[ar_sel_q*2 +: 2];
                    s_axi_rdata            = m_axi_rdata[ar_sel_q*DW +: DW];
                    m_axi_rready[ar_sel_q] = s_axi_rready;
                end
                if (s_axi_rvalid && s_axi_rready)
                    r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // State registers; init_q holds the address-ready outputs low until the first edge out of reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            init_q    <= 1'b0;
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            aw_addr_q <= '0;
            aw_prot_q <= '0;
            aw_sel_q  <= '0;
            aw_miss_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ar_addr_q <= '0;
            ar_prot_q <= '0;
            ar_sel_q  <= '0;
            ar_miss_q <= 1'b0;
        end else begin
            init_q    <= 1'b1;
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            aw_addr_q <= aw_addr_d;
            aw_prot_q <= aw_prot_d;
            aw_sel_q  <= aw_sel_d;
            aw_miss_q <= aw_miss_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            ar_addr_q <= ar_addr_d;
            ar_prot_q <= ar_prot_d;
            ar_sel_q  <= ar_sel_d;
            ar_miss_q <= ar_miss_d;
        end
    end
endmodule
